// File: rtl/ps2_kbd_pkg.sv
// Shared types and byte constants for the PS/2 keyboard controller slice.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    RST_SEND,
    RST_ACK,
    RST_BAT,
    IDLE,
    LED_CMD,
    LED_ACK,
    LED_ARG,
    LED_ARG_ACK
  } kbd_state_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] RSP_ECHO     = 8'hEE;
  localparam logic [7:0] SC_OVERRUN0  = 8'h00;
  localparam logic [7:0] SC_OVERRUN1  = 8'hFF;
  localparam logic [7:0] PFX_EXT      = 8'hE0;
  localparam logic [7:0] PFX_BRK      = 8'hF0;
  localparam logic [7:0] PFX_PAUSE    = 8'hE1;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_evt_t;

  // Bytes the command FSM claims while it is waiting for a response.
  function automatic logic is_rsp(input logic [7:0] b);
    return b inside {RSP_ACK, RSP_RESEND, RSP_BAT_OK, RSP_BAT_FAIL};
  endfunction

  // Bytes that never become key events (overrun, echo, stray responses).
  function automatic logic is_noise(input logic [7:0] b);
    return b inside {SC_OVERRUN0, SC_OVERRUN1, RSP_ECHO, RSP_BAT_OK, RSP_ACK};
  endfunction

endpackage

// File: rtl/ps2_scan_decoder.sv
// Scan-code set 2 decoder: E0/F0 prefixes, E1 pause discard, one-deep event register.
// Optional typematic repeat suppression with PS2_TYPEMATIC_FILTER_EN.
module ps2_scan_decoder
  import ps2_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       evt_ready,
`ifdef PS2_TYPEMATIC_FILTER_EN
  input  logic       filt_clr,
`endif
  output key_evt_t   evt,
  output logic       evt_valid
);

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] disc_q, disc_d;
  logic       cand;
  key_evt_t   cand_evt;
  logic       emit;
  key_evt_t   evt_q;
  logic       vld_q;

  always_comb begin
    ext_d         = ext_q;
    brk_d         = brk_q;
    disc_d        = disc_q;
    cand          = 1'b0;
    cand_evt.code = byte_data;
    cand_evt.ext  = ext_q;
    cand_evt.brk  = brk_q;
    if (byte_valid) begin
      if (disc_q != 3'd0) begin
        // Pause has no break code; the tail of the sequence is swallowed whole.
        disc_d = disc_q - 3'd1;
        if (disc_q == 3'd1) begin
          cand          = 1'b1;
          cand_evt.code = PFX_PAUSE;
          cand_evt.ext  = 1'b0;
          cand_evt.brk  = 1'b0;
        end
      end else if (byte_data == PFX_PAUSE) begin
        disc_d = 3'd7;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end else if (byte_data == PFX_EXT) begin
        ext_d = 1'b1;
      end else if (byte_data == PFX_BRK) begin
        brk_d = 1'b1;
      end else if (!is_noise(byte_data)) begin
        cand  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       filt_vld_q;
  logic [7:0] filt_code_q;
  logic       filt_ext_q;
  logic       filt_hit;

  assign filt_hit = filt_vld_q && (filt_code_q == cand_evt.code) && (filt_ext_q == cand_evt.ext);
  assign emit     = cand && !(filt_hit && !cand_evt.brk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_vld_q  <= 1'b0;
      filt_code_q <= 8'h00;
      filt_ext_q  <= 1'b0;
    end else if (filt_clr) begin
      filt_vld_q  <= 1'b0;
      filt_code_q <= 8'h00;
      filt_ext_q  <= 1'b0;
    end else if (emit) begin
      if (!cand_evt.brk) begin
        filt_vld_q  <= 1'b1;
        filt_code_q <= cand_evt.code;
        filt_ext_q  <= cand_evt.ext;
      end else if (filt_hit) begin
        filt_vld_q <= 1'b0;
      end
    end
  end
`else
  assign emit = cand;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      disc_q <= 3'd0;
      evt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      disc_q <= disc_d;
      // A byte is only accepted when the register is empty or draining this cycle.
      if (emit) begin
        evt_q <= cand_evt;
        vld_q <= 1'b1;
      end else if (evt_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign evt       = evt_q;
  assign evt_valid = vld_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: init/LED command sequencing over the PS/2 host core,
// scan-code decoding into key events. Optional typematic filter: PS2_TYPEMATIC_FILTER_EN.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int CLK_HZ             = 50000000,
  parameter int ACK_TIMEOUT_CYCLES = CLK_HZ / 50,
  parameter int BAT_TIMEOUT_CYCLES = CLK_HZ,
  parameter int RETRIES            = 3
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  output logic [7:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [2:0] led_state,
  input  logic       led_update,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       kbd_ok,
  output logic       err_pulse
);

  localparam int TMR_W = $clog2(BAT_TIMEOUT_CYCLES + 1);
  localparam int RTY_W = $clog2(RETRIES + 1);
  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] BAT_LAST = TMR_W'(BAT_TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(RETRIES - 1);

  kbd_state_t       state_q, state_d, resend_st;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [7:0]       cmd_data_q, cmd_data_d;
  logic             kbd_ok_q, kbd_ok_d;
  logic             err_q, err_d;
  logic             led_pend_q;
  logic [2:0]       led_arg_q, led_arg_d;
  logic             enter_led;
  logic             retry;
  logic             rx_en_q;
  logic             in_ack, rx_fire, rsp_fire, dec_valid;
  logic             ack_to, bat_to;
  key_evt_t         evt;

  // rx_en keeps rx_ready low while the block is held in reset.
  assign rx_ready  = rx_en_q && !(key_valid && !key_ready);
  assign rx_fire   = rx_valid && rx_ready;
  assign in_ack    = state_q inside {RST_ACK, RST_BAT, LED_ACK, LED_ARG_ACK};
  assign rsp_fire  = rx_fire && in_ack && is_rsp(rx_data);
  assign dec_valid = rx_fire && !(in_ack && is_rsp(rx_data));
  assign ack_to    = (timer_q == ACK_LAST);
  assign bat_to    = (timer_q == BAT_LAST);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rty_d       = rty_q;
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    kbd_ok_d    = kbd_ok_q;
    err_d       = 1'b0;
    led_arg_d   = led_arg_q;
    enter_led   = 1'b0;
    retry       = 1'b0;
    resend_st   = RST_SEND;
    if (in_ack) timer_d = timer_q + 1'b1;

    case (state_q)
      RST_SEND: begin
        if (!cmd_valid_q) begin
          cmd_valid_d = 1'b1;
          cmd_data_d  = CMD_RESET;
        end else if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = RST_ACK;
        end
      end
      RST_ACK: begin
        resend_st = RST_SEND;
        if (rsp_fire && rx_data == RSP_ACK) begin
          state_d = RST_BAT;
          timer_d = '0;
          rty_d   = '0;
        end else if ((rsp_fire && rx_data == RSP_RESEND) || ack_to) begin
          retry = 1'b1;
        end
      end
      RST_BAT: begin
        if (rsp_fire && rx_data == RSP_BAT_OK) begin
          kbd_ok_d = 1'b1;
          state_d  = IDLE;
        end else if ((rsp_fire && rx_data == RSP_BAT_FAIL) || bat_to) begin
          err_d = 1'b1;
        end
      end
      IDLE: begin
        if (led_pend_q) begin
          enter_led = 1'b1;
          led_arg_d = led_state;
          state_d   = LED_CMD;
        end
      end
      LED_CMD: begin
        if (!cmd_valid_q) begin
          cmd_valid_d = 1'b1;
          cmd_data_d  = CMD_SET_LED;
        end else if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = LED_ACK;
        end
      end
      LED_ACK: begin
        resend_st = LED_CMD;
        if (rsp_fire && rx_data == RSP_ACK) begin
          state_d = LED_ARG;
          rty_d   = '0;
        end else if ((rsp_fire && rx_data == RSP_RESEND) || ack_to) begin
          retry = 1'b1;
        end
      end
      LED_ARG: begin
        if (!cmd_valid_q) begin
          cmd_valid_d = 1'b1;
          cmd_data_d  = {5'b0, led_arg_q};
        end else if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = LED_ARG_ACK;
        end
      end
      LED_ARG_ACK: begin
        resend_st = LED_ARG;
        if (rsp_fire && rx_data == RSP_ACK) begin
          state_d = IDLE;
          rty_d   = '0;
        end else if ((rsp_fire && rx_data == RSP_RESEND) || ack_to) begin
          retry = 1'b1;
        end
      end
      default: state_d = RST_SEND;
    endcase

    // Retries return to the send state without re-latching the LED argument.
    if (retry) begin
      if (rty_q == RTY_LAST) begin
        err_d = 1'b1;
      end else begin
        rty_d   = rty_q + 1'b1;
        state_d = resend_st;
      end
    end

    if (err_d) begin
      state_d  = RST_SEND;
      kbd_ok_d = 1'b0;
      rty_d    = '0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= RST_SEND;
      timer_q     <= '0;
      rty_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= 8'h00;
      kbd_ok_q    <= 1'b0;
      err_q       <= 1'b0;
      led_pend_q  <= 1'b0;
      led_arg_q   <= 3'b000;
      rx_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rty_q       <= rty_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      kbd_ok_q    <= kbd_ok_d;
      err_q       <= err_d;
      // A request arriving while one is pending or in flight folds into one more sequence.
      led_pend_q  <= (led_pend_q && !enter_led) || led_update;
      led_arg_q   <= led_arg_d;
      rx_en_q     <= 1'b1;
    end
  end

  ps2_scan_decoder u_dec (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .byte_data  (rx_data),
    .byte_valid (dec_valid),
    .evt_ready  (key_ready),
`ifdef PS2_TYPEMATIC_FILTER_EN
    .filt_clr   (err_d),
`endif
    .evt        (evt),
    .evt_valid  (key_valid)
  );

  assign cmd_valid = cmd_valid_q;
  assign cmd_data  = cmd_data_q;
  assign kbd_ok    = kbd_ok_q;
  assign err_pulse = err_q;
  assign key_code  = evt.code;
  assign key_ext   = evt.ext;
  assign key_break = evt.brk;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: stimulus queues expected commands/events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ps2_kbd_ctrl;

  localparam int ACK_TO = 40;
  localparam int BAT_TO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [2:0] led_state = 3'b000;
  logic       led_update = 1'b0;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       key_ready = 1'b1;
  logic       kbd_ok;
  logic       err_pulse;

  ps2_kbd_ctrl #(
    .CLK_HZ             (1000),
    .ACK_TIMEOUT_CYCLES (ACK_TO),
    .BAT_TIMEOUT_CYCLES (BAT_TO),
    .RETRIES            (3)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .cmd_data      (cmd_data),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .led_state     (led_state),
    .led_update    (led_update),
    .key_code      (key_code),
    .key_ext       (key_ext),
    .key_break     (key_break),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .kbd_ok        (kbd_ok),
    .err_pulse     (err_pulse)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_cmd[$];
  logic [9:0] exp_key[$];
  int         cmd_cyc[$];
  int         n_cmd = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       err_prev = 1'b0;
  logic [7:0] filt_seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_accept: byte %02h never accepted", b);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_cmd(input int target, input int budget);
    int k = 0;
    while (n_cmd < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (n_cmd < target) begin
      vectors++;
      miscompares++;
      $display("FAIL cmd_wait: got %0d commands, required %0d", n_cmd, target);
    end
  endtask

  task automatic pulse_led();
    led_update = 1'b1;
    @(posedge clk);
    #1;
    led_update = 1'b0;
  endtask

  // Monitor: handshakes complete on the following posedge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (err_prev) check("err_pulse_width", {31'b0, err_pulse}, 32'd0);
        err_prev = err_pulse;
        if (err_pulse) n_err++;
        if (cmd_valid && cmd_ready) begin
          n_cmd++;
          cmd_cyc.push_back(cyc);
          if (exp_cmd.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_unexpected: got %02h, required none", cmd_data);
          end else begin
            check("cmd_byte", {24'b0, cmd_data}, {24'b0, exp_cmd.pop_front()});
          end
        end
        if (key_valid && key_ready) begin
          if (exp_key.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL key_unexpected: got %03h, required none", {key_code, key_ext, key_break});
          end else begin
            check("key_event", {22'b0, key_code, key_ext, key_break}, {22'b0, exp_key.pop_front()});
          end
        end
      end else begin
        err_prev = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int ebase;
    int d;

    // Reset values
    idle(3);
    check("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    check("rst_cmd_data",  {24'b0, cmd_data},  32'd0);
    check("rst_rx_ready",  {31'b0, rx_ready},  32'd0);
    check("rst_key_valid", {31'b0, key_valid}, 32'd0);
    check("rst_key_code",  {24'b0, key_code},  32'd0);
    check("rst_key_ext",   {31'b0, key_ext},   32'd0);
    check("rst_key_break", {31'b0, key_break}, 32'd0);
    check("rst_kbd_ok",    {31'b0, kbd_ok},    32'd0);
    check("rst_err_pulse", {31'b0, err_pulse}, 32'd0);

    // Init: FF, FA, AA
    exp_cmd.push_back(8'hFF);
    rst_n = 1'b1;
    wait_cmd(1, 20);
    check("kbd_ok_before_bat", {31'b0, kbd_ok}, 32'd0);
    send_byte(8'hFA);
    send_byte(8'hAA);
    check("kbd_ok_after_init", {31'b0, kbd_ok}, 32'd1);
    check("no_err_during_init", n_err, 32'd0);

    // Scan decoding
    exp_key.push_back({8'h1C, 1'b0, 1'b0});
    exp_key.push_back({8'h1C, 1'b0, 1'b1});
    exp_key.push_back({8'h75, 1'b1, 1'b1});
    send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    idle(5);
    check("scan_events_left", exp_key.size(), 32'd0);

    // LED update with a stalled command port, typing mid-sequence, coalesced repeats
    base = n_cmd;
    exp_cmd.push_back(8'hED);
    exp_cmd.push_back(8'h05);
    exp_cmd.push_back(8'hED);
    exp_cmd.push_back(8'h03);
    cmd_ready = 1'b0;
    led_state = 3'b101;
    pulse_led();
    idle(6);
    check("cmd_hold_valid", {31'b0, cmd_valid}, 32'd1);
    check("cmd_hold_data",  {24'b0, cmd_data},  32'hED);
    check("cmd_not_taken",  n_cmd, base);
    cmd_ready = 1'b1;
    wait_cmd(base + 1, 20);
    exp_key.push_back({8'h2A, 1'b0, 1'b0});
    send_byte(8'h2A);
    led_state = 3'b011;
    pulse_led();
    send_byte(8'hFA);
    wait_cmd(base + 2, 20);
    pulse_led();
    send_byte(8'hFA);
    wait_cmd(base + 3, 20);
    send_byte(8'hFA);
    wait_cmd(base + 4, 20);
    send_byte(8'hFA);
    idle(30);
    check("led_cmd_count", n_cmd, base + 4);
    check("led_cmds_left", exp_cmd.size(), 32'd0);
    check("led_key_left",  exp_key.size(), 32'd0);
    check("kbd_ok_after_led", {31'b0, kbd_ok}, 32'd1);

    // Backpressure
    key_ready = 1'b0;
    exp_key.push_back({8'h1C, 1'b0, 1'b0});
    exp_key.push_back({8'h32, 1'b0, 1'b0});
    send_byte(8'h1C);
    rx_data  = 8'h32;
    rx_valid = 1'b1;
    idle(4);
    @(negedge clk);
    check("bp_key_valid", {31'b0, key_valid}, 32'd1);
    check("bp_key_code",  {24'b0, key_code},  32'h1C);
    check("bp_rx_ready",  {31'b0, rx_ready},  32'd0);
    @(posedge clk);
    #1;
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    idle(3);
    check("bp_events_left", exp_key.size(), 32'd0);

    // Typematic repeats
    exp_key.push_back({8'h1C, 1'b0, 1'b0});
`ifndef PS2_TYPEMATIC_FILTER_EN
    exp_key.push_back({8'h1C, 1'b0, 1'b0});
    exp_key.push_back({8'h1C, 1'b0, 1'b0});
`endif
    exp_key.push_back({8'h1C, 1'b0, 1'b1});
    exp_key.push_back({8'h1C, 1'b0, 1'b0});
    for (int i = 0; i < 6; i++) send_byte(filt_seq[i]);
    idle(3);
    check("typematic_events_left", exp_key.size(), 32'd0);

    // Init with no ACK: retries then failure
    rst_n = 1'b0;
    idle(2);
    base  = n_cmd;
    ebase = n_err;
    for (int i = 0; i < 4; i++) exp_cmd.push_back(8'hFF);
    rst_n = 1'b1;
    wait_cmd(base + 1, 20);
    wait_cmd(base + 2, ACK_TO + 10);
    d = cmd_cyc[cmd_cyc.size() - 1] - cmd_cyc[cmd_cyc.size() - 2];
    check("retry_spacing_1", {31'b0, (d >= ACK_TO && d <= ACK_TO + 3)}, 32'd1);
    wait_cmd(base + 3, ACK_TO + 10);
    d = cmd_cyc[cmd_cyc.size() - 1] - cmd_cyc[cmd_cyc.size() - 2];
    check("retry_spacing_2", {31'b0, (d >= ACK_TO && d <= ACK_TO + 3)}, 32'd1);
    check("no_err_before_exhaust", n_err, ebase);
    wait_cmd(base + 4, ACK_TO + 10);
    check("err_after_exhaust", n_err, ebase + 1);
    check("kbd_ok_after_fail", {31'b0, kbd_ok}, 32'd0);
    check("fail_cmds_left", exp_cmd.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
